// File: rtl/conv_pkg.sv
// Shared types and width helpers for the kernel_window_conv datapath.
package conv_pkg;

   typedef enum logic [1:0] {IDLE, FILL, RUN} conv_state_t;

   function automatic int clogb2(input int value);
      int r;
      for (r = 0; (1 << r) < value; r++) begin
      end
      return r;
   endfunction

   function automatic int prod_width(input int data_w, input int coef_w);
      return data_w + coef_w;
   endfunction

   function automatic int tree_depth(input int k);
      return clogb2(k * k);
   endfunction

   function automatic int sum_width(input int data_w, input int coef_w, input int k);
      return prod_width(data_w, coef_w) + tree_depth(k);
   endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Pipelined binary adder tree: one register per level, valid/last ride alongside.
module conv_adder_tree
   import conv_pkg::*;
#(
   parameter int N     = 9,
   parameter int WIDTH = 24
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N-1:0][WIDTH-1:0]        data,
   input  logic                           in_valid,
   input  logic                           in_last,
   output logic [WIDTH+clogb2(N)-1:0]     sum,
   output logic                           out_valid,
   output logic                           out_last
);
   localparam int D  = clogb2(N);
   localparam int P  = 1 << D;
   localparam int OW = WIDTH + D;

   logic [OW-1:0] leaf [P];
   logic [OW-1:0] node [D][P];
   logic [D-1:0]  vld;
   logic [D-1:0]  lst;

   // Leaves beyond N are zero so the tree is always a full power of two.
   always_comb begin
      for (int i = 0; i < P; i++) leaf[i] = '0;
      for (int i = 0; i < N; i++) leaf[i] = OW'(data[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l < D; l++)
            for (int i = 0; i < P; i++) node[l][i] <= '0;
         vld <= '0;
         lst <= '0;
      end else begin
         for (int i = 0; i < P / 2; i++) node[0][i] <= leaf[2*i] + leaf[2*i+1];
         for (int l = 1; l < D; l++)
            for (int i = 0; i < P / 2; i++) node[l][i] <= node[l-1][2*i] + node[l-1][2*i+1];
         vld <= {vld[D-2:0], in_valid};
         lst <= {lst[D-2:0], in_last};
      end
   end

   assign sum       = node[D-1][0];
   assign out_valid = vld[D-1];
   assign out_last  = lst[D-1];

endmodule

// File: rtl/kernel_window_conv.sv
// K x K sliding-window fixed-point convolution, valid-mode, no backpressure.
// CONV_SATURATE_EN clamps oversized results to all-ones; otherwise they wrap.
module kernel_window_conv
   import conv_pkg::*;
#(
   parameter int IMAGE_COLUMN     = 512,
   parameter int IMAGE_DATA_WIDTH = 8,
   parameter int CONV_KERNEL_SIZE = 11,
   parameter int COEF_WIDTH       = 16,
   parameter int COEF_FRAC_BITS   = 14
) (
   input  logic                                                         axi_clk,
   input  logic                                                         axi_rst_n,
   input  logic [CONV_KERNEL_SIZE-1:0][IMAGE_DATA_WIDTH-1:0]            shift_data,
   input  logic [CONV_KERNEL_SIZE-1:0]                                  shift_valid,
   input  logic [CONV_KERNEL_SIZE-1:0][CONV_KERNEL_SIZE-1:0][COEF_WIDTH-1:0] coef,
   output logic [IMAGE_DATA_WIDTH-1:0]                                  m_axis_tdata,
   output logic                                                         m_axis_tvalid,
   output logic                                                         m_axis_tlast,
   output conv_state_t                                                  dbg_state
);
   localparam int K     = CONV_KERNEL_SIZE;
   localparam int DW    = IMAGE_DATA_WIDTH;
   localparam int N     = K * K;
   localparam int PW    = prod_width(DW, COEF_WIDTH);
   localparam int SW    = sum_width(DW, COEF_WIDTH, K);
   localparam int CNT_W = clogb2(IMAGE_COLUMN);
   localparam logic [CNT_W-1:0] FILL_END = CNT_W'(K - 2);
   localparam logic [CNT_W-1:0] ROW_END  = CNT_W'(IMAGE_COLUMN - 1);
   localparam logic [SW:0]      RND      = (SW + 1)'(1) << (COEF_FRAC_BITS - 1);

   conv_state_t      state_q, state_d;
   logic [CNT_W-1:0] col_cnt;
   logic             accept, win_valid, win_last;
   logic [DW-1:0]    win [K][K];
   logic             win_v, win_l;
   logic [N-1:0][PW-1:0] prod;
   logic             prod_v, prod_l;
   logic [SW-1:0]    sum;
   logic             tree_v, tree_l;
   logic [SW:0]      rsum;
   logic             rnd_v, rnd_l;
   logic [DW-1:0]    narrow;

   assign accept    = &shift_valid;
   assign dbg_state = state_q;

   // Only accepts made in RUN carry a complete window; the boundary accept is the row's last.
   always_comb begin
      state_d   = state_q;
      win_valid = 1'b0;
      win_last  = 1'b0;
      if (accept) begin
         case (state_q)
            IDLE: state_d = (col_cnt == FILL_END) ? RUN : FILL;
            FILL: if (col_cnt == FILL_END) state_d = RUN;
            RUN: begin
               win_valid = 1'b1;
               win_last  = (col_cnt == ROW_END);
               if (col_cnt == ROW_END) state_d = FILL;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         state_q <= IDLE;
         col_cnt <= '0;
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) win[r][c] <= '0;
         win_v <= 1'b0;
         win_l <= 1'b0;
      end else begin
         state_q <= state_d;
         win_v   <= win_valid;
         win_l   <= win_last;
         if (accept) begin
            col_cnt <= (col_cnt == ROW_END) ? '0 : col_cnt + CNT_W'(1);
            for (int r = 0; r < K; r++) begin
               for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
               win[r][K-1] <= shift_data[r];
            end
         end
      end
   end

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         prod   <= '0;
         prod_v <= 1'b0;
         prod_l <= 1'b0;
      end else begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               prod[r*K+c] <= PW'(win[r][c]) * PW'(coef[r][c]);
         prod_v <= win_v;
         prod_l <= win_l;
      end
   end

   conv_adder_tree #(.N(N), .WIDTH(PW)) u_tree (
      .clk       (axi_clk),
      .rst_n     (axi_rst_n),
      .data      (prod),
      .in_valid  (prod_v),
      .in_last   (prod_l),
      .sum       (sum),
      .out_valid (tree_v),
      .out_last  (tree_l)
   );

`ifdef CONV_SATURATE_EN
   localparam logic [SW:0] PIX_MAX = (SW + 1)'((1 << DW) - 1);
   logic [SW:0] shifted;
   always_comb begin
      shifted = rsum >> COEF_FRAC_BITS;
      narrow  = (shifted > PIX_MAX) ? '1 : shifted[DW-1:0];
   end
`else
   always_comb begin
      narrow = DW'(rsum >> COEF_FRAC_BITS);
   end
`endif

   // Rounding offset gets its own stage; the output register does the shift and narrowing.
   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         rsum          <= '0;
         rnd_v         <= 1'b0;
         rnd_l         <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         rsum          <= {1'b0, sum} + RND;
         rnd_v         <= tree_v;
         rnd_l         <= tree_l;
         m_axis_tdata  <= narrow;
         m_axis_tvalid <= rnd_v;
         m_axis_tlast  <= rnd_l & rnd_v;
      end
   end

endmodule

// File: tb/tb_kernel_window_conv.sv
// Directed bench for kernel_window_conv with K=3, IMAGE_COLUMN=8.
module tb_kernel_window_conv;
   import conv_pkg::*;

   localparam int K = 3, IC = 8, DW = 8, CW = 16, F = 14, LAT = 7;

   logic clk = 1'b0;
   logic rst_n;
   logic [K-1:0][DW-1:0]        shift_data;
   logic [K-1:0]                shift_valid;
   logic [K-1:0][K-1:0][CW-1:0] coef;
   logic [DW-1:0]               tdata;
   logic                        tvalid, tlast;
   conv_state_t                 dbg_state;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   logic [DW-1:0] obs_q[$];
   logic          obs_last_q[$];
   int            obs_cyc_q[$];
   logic [DW-1:0] exp_q[$];
   logic          exp_last_q[$];
   int            exp_cyc_q[$];

   kernel_window_conv #(
      .IMAGE_COLUMN(IC), .IMAGE_DATA_WIDTH(DW), .CONV_KERNEL_SIZE(K),
      .COEF_WIDTH(CW), .COEF_FRAC_BITS(F)
   ) dut (
      .axi_clk       (clk),
      .axi_rst_n     (rst_n),
      .shift_data    (shift_data),
      .shift_valid   (shift_valid),
      .coef          (coef),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tlast  (tlast),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record every result with the cycle it appeared on.
   always @(negedge clk) begin
      if (tvalid === 1'b1) begin
         obs_q.push_back(tdata);
         obs_last_q.push_back(tlast);
         obs_cyc_q.push_back(cyc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_col(input logic [K-1:0][DW-1:0] d, input logic [K-1:0] v, output int acc);
      @(negedge clk);
      shift_data  = d;
      shift_valid = v;
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   task automatic drive_row(input int row_step, input int base, output int acc[IC]);
      logic [K-1:0][DW-1:0] d;
      for (int c = 0; c < IC; c++) begin
         for (int r = 0; r < K; r++) d[r] = DW'(base + c + row_step * r);
         drive_col(d, '1, acc[c]);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         shift_valid = '0;
      end
   endtask

   task automatic clear_queues();
      obs_q.delete(); obs_last_q.delete(); obs_cyc_q.delete();
      exp_q.delete(); exp_last_q.delete(); exp_cyc_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      n_tests++;
      if (tdata !== '0 || tvalid !== 1'b0 || tlast !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%0d valid=%b last=%b, expected 0 0 0", tdata, tvalid, tlast);
      end
      n_tests++;
      if (dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      n_tests++;
      if (tvalid !== 1'b0 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_release: got valid=%b state=%0d, expected 0 %0d", tvalid, dbg_state, IDLE);
      end
   endtask

   task automatic test_ramp();
      int acc[IC];
      clear_queues();
      coef = '0;
      coef[1][1] = 16'd16384;
      drive_row(0, 0, acc);
      idle(LAT + 3);
      for (int c = K - 1; c < IC; c++) begin
         exp_q.push_back(DW'(c - 1));
         exp_last_q.push_back(c == IC - 1);
         exp_cyc_q.push_back(acc[c] + LAT);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL ramp_count: got %0d results, expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i] || obs_last_q[i] !== exp_last_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
            n_fail++;
            $display("FAIL ramp[%0d]: got data=%0d last=%b cyc=%0d, expected data=%0d last=%b cyc=%0d",
                     i, obs_q[i], obs_last_q[i], obs_cyc_q[i], exp_q[i], exp_last_q[i], exp_cyc_q[i]);
         end
      end
   endtask

   task automatic test_box();
      int acc[IC];
      clear_queues();
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) coef[r][c] = 16'd1820;
      drive_row(0, 100, acc);
      // drive_row adds the column index; rebuild a constant row instead.
      idle(LAT + 3);
      clear_queues();
      begin
         logic [K-1:0][DW-1:0] d;
         for (int r = 0; r < K; r++) d[r] = 8'd100;
         for (int c = 0; c < IC; c++) drive_col(d, '1, acc[c]);
      end
      idle(LAT + 3);
      for (int c = K - 1; c < IC; c++) begin
         exp_q.push_back(8'd100);
         exp_last_q.push_back(c == IC - 1);
         exp_cyc_q.push_back(acc[c] + LAT);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL box_count: got %0d results, expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i] || obs_last_q[i] !== exp_last_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
            n_fail++;
            $display("FAIL box[%0d]: got data=%0d last=%b cyc=%0d, expected data=%0d last=%b cyc=%0d",
                     i, obs_q[i], obs_last_q[i], obs_cyc_q[i], exp_q[i], exp_last_q[i], exp_cyc_q[i]);
         end
      end
   endtask

   task automatic test_overflow();
      int acc[IC];
      logic [K-1:0][DW-1:0] d;
      logic [DW-1:0] want;
`ifdef CONV_SATURATE_EN
      want = 8'd255;
`else
      want = 8'd144;
`endif
      clear_queues();
      coef = '0;
      coef[1][1] = 16'd32768;
      for (int r = 0; r < K; r++) d[r] = 8'd200;
      for (int c = 0; c < IC; c++) drive_col(d, '1, acc[c]);
      idle(LAT + 3);
      n_tests++;
      if (obs_q.size() != IC - K + 1) begin
         n_fail++;
         $display("FAIL overflow_count: got %0d results, expected %0d", obs_q.size(), IC - K + 1);
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== want || obs_cyc_q[i] != acc[i + K - 1] + LAT) begin
            n_fail++;
            $display("FAIL overflow[%0d]: got data=%0d cyc=%0d, expected data=%0d cyc=%0d",
                     i, obs_q[i], obs_cyc_q[i], want, acc[i + K - 1] + LAT);
         end
      end
   endtask

   task automatic test_gap();
      int acc[IC];
      int dummy;
      logic [K-1:0][DW-1:0] d, junk;
      clear_queues();
      coef = '0;
      coef[0][2] = 16'd16384;   // newest row, newest column
      for (int r = 0; r < K; r++) junk[r] = 8'hEE;
      for (int c = 0; c < IC; c++) begin
         if (c == 4) begin
            repeat (5) drive_col(junk, 3'b011, dummy);
            n_tests++;
            if (dbg_state !== RUN) begin
               n_fail++;
               $display("FAIL gap_state: got %0d, expected %0d", dbg_state, RUN);
            end
         end
         for (int r = 0; r < K; r++) d[r] = DW'(c + 16 * r);
         drive_col(d, '1, acc[c]);
      end
      idle(LAT + 3);
      for (int c = K - 1; c < IC; c++) begin
         exp_q.push_back(DW'(c));
         exp_last_q.push_back(c == IC - 1);
         exp_cyc_q.push_back(acc[c] + LAT);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL gap_count: got %0d results, expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i] || obs_last_q[i] !== exp_last_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
            n_fail++;
            $display("FAIL gap[%0d]: got data=%0d last=%b cyc=%0d, expected data=%0d last=%b cyc=%0d",
                     i, obs_q[i], obs_last_q[i], obs_cyc_q[i], exp_q[i], exp_last_q[i], exp_cyc_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc_a[IC];
      int acc_b[IC];
      int n_last;
      clear_queues();
      coef = '0;
      coef[1][1] = 16'd16384;
      drive_row(0, 0, acc_a);
      drive_row(0, 0, acc_b);
      idle(LAT + 3);
      for (int c = K - 1; c < IC; c++) begin
         exp_q.push_back(DW'(c - 1));
         exp_last_q.push_back(c == IC - 1);
         exp_cyc_q.push_back(acc_a[c] + LAT);
      end
      for (int c = K - 1; c < IC; c++) begin
         exp_q.push_back(DW'(c - 1));
         exp_last_q.push_back(c == IC - 1);
         exp_cyc_q.push_back(acc_b[c] + LAT);
      end
      n_last = 0;
      foreach (obs_last_q[i]) if (obs_last_q[i] === 1'b1) n_last++;
      n_tests++;
      if (obs_q.size() != 12 || n_last != 2) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d results %0d lasts, expected 12 results 2 lasts", obs_q.size(), n_last);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i] || obs_last_q[i] !== exp_last_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
            n_fail++;
            $display("FAIL b2b[%0d]: got data=%0d last=%b cyc=%0d, expected data=%0d last=%b cyc=%0d",
                     i, obs_q[i], obs_last_q[i], obs_cyc_q[i], exp_q[i], exp_last_q[i], exp_cyc_q[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int acc[IC];
      logic [K-1:0][DW-1:0] d;
      clear_queues();
      coef = '0;
      coef[1][1] = 16'd16384;
      for (int c = 0; c < 6; c++) begin
         for (int r = 0; r < K; r++) d[r] = DW'(c);
         drive_col(d, '1, acc[c]);
      end
      shift_valid = '0;
      while (cyc < acc[2] + LAT) @(negedge clk);
      #1;
      n_tests++;
      if (tvalid !== 1'b1 || tdata !== 8'd1) begin
         n_fail++;
         $display("FAIL pre_reset_out: got valid=%b data=%0d, expected 1 1", tvalid, tdata);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (tvalid !== 1'b0 || tdata !== '0 || tlast !== 1'b0 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b data=%0d last=%b state=%0d, expected 0 0 0 %0d",
                  tvalid, tdata, tlast, dbg_state, IDLE);
      end
      clear_queues();
      @(negedge clk);
      rst_n = 1'b1;
      drive_row(0, 0, acc);
      idle(LAT + 3);
      for (int c = K - 1; c < IC; c++) begin
         exp_q.push_back(DW'(c - 1));
         exp_last_q.push_back(c == IC - 1);
         exp_cyc_q.push_back(acc[c] + LAT);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL mid_reset_count: got %0d results, expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i] || obs_last_q[i] !== exp_last_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
            n_fail++;
            $display("FAIL mid_reset[%0d]: got data=%0d last=%b cyc=%0d, expected data=%0d last=%b cyc=%0d",
                     i, obs_q[i], obs_last_q[i], obs_cyc_q[i], exp_q[i], exp_last_q[i], exp_cyc_q[i]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n       = 1'b0;
      shift_data  = '0;
      shift_valid = '0;
      coef        = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_ramp();
      test_box();
      test_overflow();
      test_gap();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
